// File: rtl/clk_enable_pkg.sv
// ---------------------------------------------------------------------------
// clk_enable_pkg
// Shared constants for the clock-enable generator and its channels.
//   MAX_CH        : maximum number of channels a generator instance supports
//   DIV_DISABLED  : divisor value that switches a channel off
//   DIV_UART / DIV_RDCLK / DIV_ADC : common divisors for the downstream users
//   ch_sel_w()    : width of a channel-select field (never less than 1 bit)
// ---------------------------------------------------------------------------
package clk_enable_pkg;

  localparam int MAX_CH       = 16;
  localparam int DIV_DISABLED = 0;

  localparam int DIV_UART     = 9;
  localparam int DIV_RDCLK    = 18;
  localparam int DIV_ADC      = 50;

  function automatic int ch_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_enable_ch.sv
// ---------------------------------------------------------------------------
// clk_enable_ch
// One clock-enable channel: active divisor, shadow divisor with pending flag,
// free-running counter, single-cycle tick and 50 % square wave.
// Ports:
//   clk_i     : system clock
//   rst_i     : synchronous reset, active low
//   run_i     : lock-qualified enable; 0 holds the channel idle
//   sync_i    : restart the counter and apply any pending divisor now
//   wr_i      : divisor write strobe, already decoded for this channel
//   wr_div_i  : divisor to store in the shadow register
//   tick_o    : one-cycle enable strobe, period = div
//   wave_o    : square wave toggling on each tick, period = 2*div
// ---------------------------------------------------------------------------
module clk_enable_ch
  import clk_enable_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = DIV_UART
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             tick_o,
  output logic             wave_o
);

  localparam logic [CNT_W-1:0] DIS = CNT_W'(DIV_DISABLED);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             wave_q, wave_d;

  logic [CNT_W-1:0] shadow_eff;
  logic             pend_eff;
  logic             wrap;
  logic             restart;
  logic             take;

  always_comb begin
    // A write in this cycle is visible to the apply logic immediately, so a
    // write coinciding with sync (or with a wrap) takes effect right away.
    shadow_eff = wr_i ? wr_div_i : shadow_q;
    pend_eff   = pend_q | wr_i;

    wrap = (div_q != DIS) && (cnt_q == div_q - ONE);

    // Restart conditions hold the counter at 0 and let a pending divisor
    // load without waiting for a wrap. A pending divisor of 0 is applied at
    // once so that disabling a channel silences it on the next cycle.
    restart = !run_i || sync_i || (div_q == DIS) ||
              (pend_eff && (shadow_eff == DIS));

    take = pend_eff && (restart || wrap);

    shadow_d = shadow_eff;
    pend_d   = pend_eff && !take;
    div_d    = take ? shadow_eff : div_q;

    if (restart) begin
      cnt_d  = '0;
      tick_d = 1'b0;
      wave_d = 1'b0;
    end else if (wrap) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      wave_d = ~wave_q;
    end else begin
      cnt_d  = cnt_q + ONE;
      tick_d = 1'b0;
      wave_d = wave_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      div_q    <= DEF;
      shadow_q <= DEF;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      wave_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      wave_q   <= wave_d;
    end
  end

  assign tick_o = tick_q;
  assign wave_o = wave_q;

endmodule

// File: rtl/clk_enable_gen.sv
// ---------------------------------------------------------------------------
// clk_enable_gen
// Multi-channel clock-enable generator gated by the MMCM locked indication.
// Optional macro: CLKEN_LOCK_SYNC_EN -- when defined, locked_i passes through
// a 2-flop synchronizer before the active register (locked_i -> active_o
// becomes 3 cycles instead of 1).
// Ports:
//   clk_i     : system clock
//   rst_i     : synchronous reset, active low
//   locked_i  : MMCM locked; 0 holds all channels idle
//   sync_i    : single-cycle pulse that phase-aligns all channels
//   wr_en_i   : divisor write strobe
//   wr_ch_i   : channel targeted by the write (out-of-range is ignored)
//   wr_div_i  : new divisor, 0 disables the channel
//   tick_o    : per-channel one-cycle enable strobe
//   wave_o    : per-channel square wave
//   active_o  : registered lock-qualified enable
// ---------------------------------------------------------------------------
module clk_enable_gen
  import clk_enable_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int CNT_W   = 16,
  parameter  int DEF_DIV = DIV_UART,
  localparam int CH_W    = ch_sel_w(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              locked_i,
  input  logic              sync_i,
  input  logic              wr_en_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [CNT_W-1:0]  wr_div_i,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] wave_o,
  output logic              active_o
);

  logic active_q;
  logic active_d;
  logic run;

`ifdef CLKEN_LOCK_SYNC_EN
  logic [1:0] lock_sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      lock_sync_q <= 2'b00;
    end else begin
      lock_sync_q <= {lock_sync_q[0], locked_i};
    end
  end

  assign active_d = lock_sync_q[1];
`else
  assign active_d = locked_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      active_q <= 1'b0;
    end else begin
      active_q <= active_d;
    end
  end

  // Channels count only while active is high both now and next cycle. Using
  // the incoming value makes a lock loss clear the channels on the same edge
  // that drops active_o, so no tick escapes after the loss; requiring the
  // current value makes counting start from 0 in the first active cycle.
  assign run      = active_q & active_d;
  assign active_o = active_q;

  logic wr_ok;
  assign wr_ok = wr_en_i && (int'(wr_ch_i) < NUM_CH);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic wr_sel;
    assign wr_sel = wr_ok && (int'(wr_ch_i) == gi);

    clk_enable_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .run_i    (run),
      .sync_i   (sync_i),
      .wr_i     (wr_sel),
      .wr_div_i (wr_div_i),
      .tick_o   (tick_o[gi]),
      .wave_o   (wave_o[gi])
    );
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// ---------------------------------------------------------------------------
// tb_clk_enable_gen
// Directed bench for clk_enable_gen. Three channels are used so that a
// channel index equal to the channel count is representable on wr_ch_i.
// A behavioural model tracks each channel as a period origin plus divisor
// and derives tick/wave from elapsed cycles; a compare process checks the
// DUT against it every cycle, and literal expectations pin key instants.
// ---------------------------------------------------------------------------
module tb_clk_enable_gen;

  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int DEF = 9;
`ifdef CLKEN_LOCK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic           clk = 1'b0;
  logic           rst_i = 1'b0;
  logic           locked_i = 1'b1;
  logic           sync_i = 1'b0;
  logic           wr_en_i = 1'b0;
  logic [1:0]     wr_ch_i = '0;
  logic [CW-1:0]  wr_div_i = '0;
  logic [NCH-1:0] tick_o;
  logic [NCH-1:0] wave_o;
  logic           active_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fail_prints = 0;

  always #5 clk = ~clk;

  clk_enable_gen #(
    .NUM_CH  (NCH),
    .CNT_W   (CW),
    .DEF_DIV (DEF)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .locked_i (locked_i),
    .sync_i   (sync_i),
    .wr_en_i  (wr_en_i),
    .wr_ch_i  (wr_ch_i),
    .wr_div_i (wr_div_i),
    .tick_o   (tick_o),
    .wave_o   (wave_o),
    .active_o (active_o)
  );

  // ---------------- behavioural model ----------------
  int  m_div   [NCH];
  int  m_shadow[NCH];
  int  m_org   [NCH];   // edge index at which the current period train began
  bit  m_pend  [NCH];
  bit  m_tick  [NCH];
  bit  m_wave  [NCH];
  bit  m_pipe  [3];     // locked_i delay line feeding the active flag
  bit  m_act;
  bit  m_valid = 1'b0;

  always @(posedge clk) begin : model
    bit prev_act;
    bit run;
    bit restart;
    cyc = cyc + 1;
    if (!rst_i) begin
      for (int c = 0; c < NCH; c++) begin
        m_div[c] = DEF; m_shadow[c] = DEF; m_pend[c] = 1'b0;
        m_tick[c] = 1'b0; m_wave[c] = 1'b0; m_org[c] = cyc;
      end
      for (int i = 0; i < 3; i++) m_pipe[i] = 1'b0;
      m_act   = 1'b0;
      m_valid = 1'b1;
    end else begin
      prev_act = m_act;
      for (int i = 2; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = locked_i;
      m_act = m_pipe[LAT-1];
      run = prev_act && m_act;
      for (int c = 0; c < NCH; c++) begin
        if (wr_en_i && int'(wr_ch_i) == c) begin
          m_shadow[c] = int'(wr_div_i);
          m_pend[c]   = 1'b1;
        end
        restart = !run || sync_i || m_div[c] == 0 || (m_pend[c] && m_shadow[c] == 0);
        if (restart) begin
          if (m_pend[c]) begin m_div[c] = m_shadow[c]; m_pend[c] = 1'b0; end
          m_org[c] = cyc; m_tick[c] = 1'b0; m_wave[c] = 1'b0;
        end else if ((cyc - m_org[c]) % m_div[c] == 0) begin
          m_tick[c] = 1'b1;
          m_wave[c] = ~m_wave[c];
          if (m_pend[c]) begin
            m_div[c] = m_shadow[c]; m_pend[c] = 1'b0; m_org[c] = cyc;
          end
        end else begin
          m_tick[c] = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    logic [NCH-1:0] exp_tick;
    logic [NCH-1:0] exp_wave;
    if (m_valid) begin
      for (int c = 0; c < NCH; c++) begin
        exp_tick[c] = m_tick[c];
        exp_wave[c] = m_wave[c];
      end
      checks = checks + 1;
      if (tick_o !== exp_tick || wave_o !== exp_wave || active_o !== m_act) begin
        failures = failures + 1;
        if (fail_prints < 20) begin
          fail_prints = fail_prints + 1;
          $display("FAIL model cyc=%0d tick got=%b exp=%b wave got=%b exp=%b active got=%b exp=%b",
                   cyc, tick_o, exp_tick, wave_o, exp_wave, active_o, m_act);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic at_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
    end
  endtask

  task automatic pulse_write(input int ch, input int dv);
    wr_en_i  = 1'b1;
    wr_ch_i  = 2'(ch);
    wr_div_i = CW'(dv);
    @(negedge clk);
    wr_en_i  = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int r, d, o, s, d2, e;
    repeat (3) @(negedge clk);
    lit("reset_tick",   8'(tick_o),   8'b000);
    lit("reset_wave",   8'(wave_o),   8'b000);
    lit("reset_active", 8'(active_o), 8'b0);
    $display("txn reset released at cyc=%0d", cyc);
    rst_i = 1'b1;
    r = cyc;

    // Default divisor with locked held high.
    at_edge(r + LAT + 8);  lit("def_pre_tick", 8'(tick_o), 8'b000);
    at_edge(r + LAT + 9);  lit("def_tick1", 8'(tick_o), 8'b111);
                           lit("def_wave1", 8'(wave_o), 8'b111);
    at_edge(r + LAT + 18); lit("def_tick2", 8'(tick_o), 8'b111);
                           lit("def_wave2", 8'(wave_o), 8'b000);
    at_edge(r + LAT + 27); lit("def_tick3", 8'(tick_o), 8'b111);
    $display("txn default ticks checked through cyc=%0d", cyc);

    // Lock gating: drop for 50 cycles, then regain.
    locked_i = 1'b0;
    d = cyc + 1;
    at_edge(d + LAT - 1);
    lit("lockloss_active", 8'(active_o), 8'b0);
    lit("lockloss_wave",   8'(wave_o),   8'b000);
    at_edge(d + 50);
    locked_i = 1'b1;
    o = cyc + 1 + LAT - 1;
    $display("txn lock regained, counting origin cyc=%0d", o);

    // Glitch-free write on ch1 while its counter reads 3.
    at_edge(o + 3);
    pulse_write(1, 4);
    $display("txn write ch1 div=4 at cyc=%0d", cyc);
    at_edge(o + 8);  lit("relock_pre_tick", 8'(tick_o), 8'b000);
    at_edge(o + 9);  lit("relock_tick",     8'(tick_o), 8'b111);
    at_edge(o + 13); lit("ch1_div4_a",      8'(tick_o), 8'b010);
    at_edge(o + 17); lit("ch1_div4_b",      8'(tick_o), 8'b010);
    at_edge(o + 18); lit("ch0_unaffected",  8'(tick_o), 8'b101);

    // Disable ch2 while its wave is high, then an out-of-range write.
    at_edge(o + 27);
    lit("ch2_wave_before", 8'(wave_o[2]), 8'b1);
    pulse_write(2, 0);
    $display("txn write ch2 div=0 at cyc=%0d", cyc);
    lit("ch2_off_wave", 8'(wave_o[2]), 8'b0);
    lit("ch2_off_tick", 8'(tick_o[2]), 8'b0);
    at_edge(o + 36); lit("ch2_silent", 8'(tick_o), 8'b001);
    pulse_write(NCH, 5);
    $display("txn out-of-range write ch=%0d at cyc=%0d", NCH, cyc);
    at_edge(o + 45); lit("after_oor", 8'(tick_o), 8'b011);

    // Sync alignment: pending write on ch0, write+sync on ch1.
    pulse_write(0, 6);
    at_edge(o + 48);
    sync_i = 1'b1; wr_en_i = 1'b1; wr_ch_i = 2'd1; wr_div_i = CW'(3);
    @(negedge clk);
    sync_i = 1'b0; wr_en_i = 1'b0;
    s = cyc;
    $display("txn sync with ch1 div=3 at cyc=%0d", s);
    lit("sync_wave_clr", 8'(wave_o), 8'b000);
    lit("sync_tick_clr", 8'(tick_o), 8'b000);
    at_edge(s + 3);  lit("sync_ch1_first", 8'(tick_o), 8'b010);
    at_edge(s + 6);  lit("sync_coincide1", 8'(tick_o), 8'b011);
    at_edge(s + 9);  lit("sync_ch1_third", 8'(tick_o), 8'b010);
    at_edge(s + 12); lit("sync_coincide2", 8'(tick_o), 8'b011);

    // Mid-period lock loss.
    at_edge(s + 14);
    locked_i = 1'b0;
    d2 = cyc + 1;
    at_edge(d2 + LAT - 1);
    $display("txn lock dropped, checked at cyc=%0d", cyc);
    lit("abort_active", 8'(active_o), 8'b0);
    lit("abort_tick",   8'(tick_o),   8'b000);
    lit("abort_wave",   8'(wave_o),   8'b000);
    at_edge(d2 + 5);
    locked_i = 1'b1;

    // Reset mid-count restores the default divisor.
    at_edge(d2 + 12);
    rst_i = 1'b0;
    e = cyc + 1;
    at_edge(e);
    $display("txn mid-count reset at cyc=%0d", e);
    lit("midrst_tick",   8'(tick_o),   8'b000);
    lit("midrst_wave",   8'(wave_o),   8'b000);
    lit("midrst_active", 8'(active_o), 8'b0);
    rst_i = 1'b1;
    at_edge(e + LAT + 8); lit("midrst_pre_tick", 8'(tick_o), 8'b000);
    at_edge(e + LAT + 9); lit("midrst_div9",     8'(tick_o), 8'b111);
    at_edge(e + LAT + 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
